spi_display_cfg: RTL and testbench

SPI_DISPLAY_CFG -- requirements
Module: spi_display_cfg

---
 rtl/spi_display_cfg_pkg.sv | 16 +
 rtl/spi_shifter.sv | 64 ++++++
 rtl/spi_display_cfg.sv | 168 ++++++++++++++++
 tb/tb_spi_display_cfg.sv | 331 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_display_cfg_pkg.sv
// Shared state encodings and SPI mode constants for the bit-banged SPI blocks.
package spi_display_cfg_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_HOLD  = 2'd2,
    ST_GAP   = 2'd3
  } spi_state_e;

  // Clock phase: data captured on the trailing edge of each clock period.
  localparam bit SPI_CPHA_TRAIL = 1'b1;
  // Bit order: least significant bit leaves the wire first.
  localparam bit SPI_LSB_FIRST  = 1'b1;

endpackage

// File: rtl/spi_shifter.sv
// W-bit data path: parallel load, serial shift-out toward the wire, serial
// shift-in from the wire, both in the same bit order.
module spi_shifter
  import spi_display_cfg_pkg::*;
#(
  parameter int W         = 8,
  parameter bit LSB_FIRST = 1'b0,
  parameter bit CPHA      = 1'b0
) (
  input  logic         clock_i,
  input  logic         reset_i,
  input  logic         load_i,
  input  logic [W-1:0] data_i,
  input  logic         shift_i,
  input  logic         sample_i,
  input  logic         miso_i,
  output logic         first_bit_o,
  output logic         next_bit_o,
  output logic [W-1:0] rx_next_o
);

  localparam bit LSBF = (LSB_FIRST == SPI_LSB_FIRST);

  logic [W-1:0] tx_q, tx_d;
  logic [W-1:0] rx_q, rx_d;

  // Move the next bit to be transmitted into the head position.
  function automatic logic [W-1:0] advance(input logic [W-1:0] v);
    advance = LSBF ? (v >> 1) : (v << 1);
  endfunction

  // Head-bit selection, receive assembly and next-state of both registers.
  // With leading-edge sampling the first bit is driven at load time, so the
  // register is pre-advanced; with trailing-edge sampling the first shift
  // event itself drives bit 0.
  always_comb begin
    first_bit_o = LSBF ? data_i[0] : data_i[W-1];
    next_bit_o  = LSBF ? tx_q[0] : tx_q[W-1];
    rx_next_o   = rx_q;
    if (sample_i) begin
      rx_next_o = LSBF ? {miso_i, rx_q[W-1:1]} : {rx_q[W-2:0], miso_i};
    end
    tx_d = tx_q;
    rx_d = rx_next_o;
    if (load_i) begin
      tx_d = (CPHA == SPI_CPHA_TRAIL) ? data_i : advance(data_i);
      rx_d = '0;
    end else if (shift_i) begin
      tx_d = advance(tx_q);
    end
  end

  // Register update with synchronous clear.
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      tx_q <= '0;
      rx_q <= '0;
    end else begin
      tx_q <= tx_d;
      rx_q <= rx_d;
    end
  end

endmodule

// File: rtl/spi_display_cfg.sv
// Bit-banged SPI master for display configuration words: pops words from a
// source, shifts them out with a data/command flag, captures the reply.
// Handshake: get is high exactly on an edge where the source word is taken;
// the source must hold data/dc valid whenever empty=0.
module spi_display_cfg
  import spi_display_cfg_pkg::*;
#(
  parameter int W         = 8,
  parameter bit CPOL      = 1'b0,
  parameter bit CPHA      = 1'b0,
  parameter bit LSB_FIRST = 1'b0,
  parameter int GAP       = 0
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         step,
  input  logic         dc,
  input  logic [W-1:0] data,
  output logic         get,
  input  logic         empty,
  output logic         spi_cs_n,
  output logic         spi_clock,
  output logic         spi_dc,
  output logic         spi_mosi,
  input  logic         spi_miso,
  output logic [W-1:0] rx_data,
  output logic         rx_valid,
  output logic [1:0]   dbg_state
);

  localparam int CW = $clog2(2 * W + 1);
  localparam logic [CW-1:0] LAST_TOGGLE = CW'(2 * W - 1);
  localparam int GW = (GAP > 1) ? $clog2(GAP) : 1;
  localparam logic [GW-1:0] GAP_LAST = GW'((GAP > 0) ? GAP - 1 : 0);

  spi_state_e   state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [GW-1:0] gap_q, gap_d;
  logic         cs_n_q, cs_n_d;
  logic         sclk_q, sclk_d;
  logic         dc_q, dc_d;
  logic         mosi_q, mosi_d;
  logic [W-1:0] rx_data_q, rx_data_d;
  logic         rx_valid_q, rx_valid_d;

  logic         odd_toggle, last_toggle;
  logic         shift_en, sample_en;
  logic         first_bit, next_bit;
  logic [W-1:0] rx_next;

  spi_shifter #(
    .W        (W),
    .LSB_FIRST(LSB_FIRST),
    .CPHA     (CPHA)
  ) u_shifter (
    .clock_i    (clock),
    .reset_i    (reset),
    .load_i     (get),
    .data_i     (data),
    .shift_i    (shift_en),
    .sample_i   (sample_en),
    .miso_i     (spi_miso),
    .first_bit_o(first_bit),
    .next_bit_o (next_bit),
    .rx_next_o  (rx_next)
  );

  // Pop strobe: only on a step, with a word present, from IDLE or HOLD.
  assign get = step & ~empty & ~reset & ((state_q == ST_IDLE) | (state_q == ST_HOLD));

  // cnt_q holds completed toggles, so the toggle about to happen is odd when
  // the count is even.
  assign odd_toggle  = ~cnt_q[0];
  assign last_toggle = (cnt_q == LAST_TOGGLE);

  // Next-state and output logic; word load on get overrides the case below.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    gap_d      = gap_q;
    cs_n_d     = cs_n_q;
    sclk_d     = sclk_q;
    dc_d       = dc_q;
    mosi_d     = mosi_q;
    rx_data_d  = rx_data_q;
    rx_valid_d = 1'b0;
    shift_en   = 1'b0;
    sample_en  = 1'b0;
    case (state_q)
      ST_SHIFT: begin
        if (step) begin
          sclk_d    = ~sclk_q;
          cnt_d     = cnt_q + 1'b1;
          sample_en = (CPHA == SPI_CPHA_TRAIL) ? ~odd_toggle : odd_toggle;
          shift_en  = (CPHA == SPI_CPHA_TRAIL) ? odd_toggle : (~odd_toggle & ~last_toggle);
          if (shift_en) begin
            mosi_d = next_bit;
          end
          if (last_toggle) begin
            state_d    = ST_HOLD;
            sclk_d     = CPOL;
            rx_data_d  = rx_next;
            rx_valid_d = 1'b1;
          end
        end
      end
      ST_HOLD: begin
        if (step && empty) begin
          cs_n_d = 1'b1;
          gap_d  = '0;
          state_d = (GAP > 0) ? ST_GAP : ST_IDLE;
        end
      end
      ST_GAP: begin
        if (step) begin
          if (gap_q == GAP_LAST) begin
            state_d = ST_IDLE;
          end else begin
            gap_d = gap_q + 1'b1;
          end
        end
      end
      default: ;
    endcase
    if (get) begin
      state_d = ST_SHIFT;
      cnt_d   = '0;
      cs_n_d  = 1'b0;
      sclk_d  = CPOL;
      dc_d    = dc;
      mosi_d  = first_bit;
    end
  end

  // State and output registers; reset aborts any transfer in progress.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      gap_q      <= '0;
      cs_n_q     <= 1'b1;
      sclk_q     <= CPOL;
      dc_q       <= 1'b0;
      mosi_q     <= 1'b0;
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      gap_q      <= gap_d;
      cs_n_q     <= cs_n_d;
      sclk_q     <= sclk_d;
      dc_q       <= dc_d;
      mosi_q     <= mosi_d;
      rx_data_q  <= rx_data_d;
      rx_valid_q <= rx_valid_d;
    end
  end

  assign spi_cs_n  = cs_n_q;
  assign spi_clock = sclk_q;
  assign spi_dc    = dc_q;
  assign spi_mosi  = mosi_q;
  assign rx_data   = rx_data_q;
  assign rx_valid  = rx_valid_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_spi_display_cfg.sv
// Bench for spi_display_cfg: three instances (mode 0 MSB-first, mode 3
// LSB-first W=9, mode 0 with GAP=3), each with miso looped back to mosi.
module tb_spi_display_cfg;
  import spi_display_cfg_pkg::*;

  // ---------------- clock / reset ----------------
  logic clock = 1'b0;
  always #5 clock = ~clock;
  logic reset = 1'b1;
  logic step  = 1'b0;

  logic [2:0] empty_w = 3'b111;
  logic [2:0] dc_w    = 3'b000;
  logic [7:0] data_a  = 8'h00;
  logic [8:0] data_b  = 9'h000;
  logic [7:0] data_c  = 8'h00;

  logic [2:0] get_w, cs_n_w, sclk_w, sdc_w, mosi_w, rxv_w;
  logic [7:0] rx_a, rx_c;
  logic [8:0] rx_b;
  logic [1:0] st_a, st_b, st_c;

  spi_display_cfg #(.W(8)) dut_a (
    .clock(clock), .reset(reset), .step(step), .dc(dc_w[0]), .data(data_a),
    .get(get_w[0]), .empty(empty_w[0]), .spi_cs_n(cs_n_w[0]), .spi_clock(sclk_w[0]),
    .spi_dc(sdc_w[0]), .spi_mosi(mosi_w[0]), .spi_miso(mosi_w[0]),
    .rx_data(rx_a), .rx_valid(rxv_w[0]), .dbg_state(st_a)
  );

  spi_display_cfg #(.W(9), .CPOL(1'b1), .CPHA(1'b1), .LSB_FIRST(1'b1)) dut_b (
    .clock(clock), .reset(reset), .step(step), .dc(dc_w[1]), .data(data_b),
    .get(get_w[1]), .empty(empty_w[1]), .spi_cs_n(cs_n_w[1]), .spi_clock(sclk_w[1]),
    .spi_dc(sdc_w[1]), .spi_mosi(mosi_w[1]), .spi_miso(mosi_w[1]),
    .rx_data(rx_b), .rx_valid(rxv_w[1]), .dbg_state(st_b)
  );

  spi_display_cfg #(.W(8), .GAP(3)) dut_c (
    .clock(clock), .reset(reset), .step(step), .dc(dc_w[2]), .data(data_c),
    .get(get_w[2]), .empty(empty_w[2]), .spi_cs_n(cs_n_w[2]), .spi_clock(sclk_w[2]),
    .spi_dc(sdc_w[2]), .spi_mosi(mosi_w[2]), .spi_miso(mosi_w[2]),
    .rx_data(rx_c), .rx_valid(rxv_w[2]), .dbg_state(st_c)
  );

  // ---------------- bookkeeping ----------------
  int checks = 0;
  int failures = 0;
  logic [11:0] exp_tx_q[$];   // {dut id, dc, word}
  logic [11:0] exp_rx_q[$];   // {dut id, 0, word}
  logic [9:0]  src_q[$];      // {dc, word} queued for the active instance
  int get_t[$];
  int rise_t[$];
  int active_dut = 0;
  int step_cnt = 0;
  logic stepped = 1'b0;
  logic rst_edge = 1'b1;
  int stall_bad = 0;
  int gap_bad = 0;
  int stray_get = 0;
  int idle_bad = 0;
  logic idle_watch = 1'b0;

  function automatic int wd(input int d);
    return (d == 1) ? 9 : 8;
  endfunction

  function automatic logic [8:0] rx_of(input int d);
    case (d)
      0: return {1'b0, rx_a};
      1: return rx_b;
      default: return {1'b0, rx_c};
    endcase
  endfunction

  function automatic logic [1:0] st_of(input int d);
    case (d)
      0: return st_a;
      1: return st_b;
      default: return st_c;
    endcase
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic fail_unexpected(input string name, input logic [31:0] act);
    checks++;
    failures++;
    $display("FAIL %s: got %0h expected nothing", name, act);
  endtask

  // ---------------- driver processes ----------------
  // Bit-rate strobe: one step every other clock.
  initial forever begin
    @(negedge clock);
    step = ~step;
  end

  // Source model: presents the head of src_q to the active instance.
  initial forever begin
    @(negedge clock);
    #1;
    for (int d = 0; d < 3; d++) begin
      empty_w[d] = !((d == active_dut) && (src_q.size() > 0));
    end
    if (src_q.size() > 0) begin
      dc_w[active_dut] = src_q[0][9];
      case (active_dut)
        0: data_a = src_q[0][7:0];
        1: data_b = src_q[0][8:0];
        default: data_c = src_q[0][7:0];
      endcase
    end
  end

  // Edge recorder: pops the source on get and timestamps gets in steps.
  initial forever begin
    @(posedge clock);
    stepped  = step;
    rst_edge = reset;
    if (get_w[active_dut]) begin
      if (!step) stray_get++;
      get_t.push_back(step_cnt);
      if (src_q.size() > 0) void'(src_q.pop_front());
    end
    for (int d = 0; d < 3; d++) begin
      if (d != active_dut && get_w[d]) stray_get++;
    end
    if (step) step_cnt++;
  end

  // ---------------- monitor / scoreboard ----------------
  logic [8:0]  sh[3];
  int          bitc[3];
  logic [2:0]  psclk = 3'b010;
  logic [2:0]  pcs = 3'b111;
  logic [11:0] snap = 12'h0;

  initial begin
    for (int d = 0; d < 3; d++) begin
      sh[d] = '0;
      bitc[d] = 0;
    end
    forever begin
      @(negedge clock);
      for (int d = 0; d < 3; d++) begin
        // Slave model: both configurations capture on the rising spi_clock.
        if (cs_n_w[d]) begin
          bitc[d] = 0;
        end else if (sclk_w[d] && !psclk[d]) begin
          if (d == 1) sh[d] = {mosi_w[d], sh[d][8:1]};
          else        sh[d] = {sh[d][7:0], mosi_w[d]};
          bitc[d]++;
          if (bitc[d] == wd(d)) begin
            logic [8:0] word;
            bitc[d] = 0;
            word = (d == 1) ? sh[d] : {1'b0, sh[d][7:0]};
            if (exp_tx_q.size() == 0) fail_unexpected("tx_word", {2'(d), sdc_w[d], word});
            else chk("tx_word", {2'(d), sdc_w[d], word}, exp_tx_q.pop_front());
          end
        end
        if (rxv_w[d]) begin
          if (exp_rx_q.size() == 0) fail_unexpected("rx_word", {2'(d), 1'b0, rx_of(d)});
          else chk("rx_word", {2'(d), 1'b0, rx_of(d)}, exp_rx_q.pop_front());
        end
      end
      if (!stepped && !rst_edge && ({cs_n_w, sclk_w, sdc_w, mosi_w} != snap)) stall_bad++;
      snap = {cs_n_w, sclk_w, sdc_w, mosi_w};
      if (st_c == ST_GAP && get_w[2]) gap_bad++;
      if (idle_watch && (get_w[0] || rxv_w[0] || sclk_w[0] || !cs_n_w[0])) idle_bad++;
      if (cs_n_w[active_dut] && !pcs[active_dut] && !rst_edge) rise_t.push_back(step_cnt - 1);
      pcs   = cs_n_w;
      psclk = sclk_w;
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic push_word(input int d, input logic dcv, input logic [8:0] w);
    src_q.push_back({dcv, w});
    exp_tx_q.push_back({2'(d), dcv, w});
    exp_rx_q.push_back({2'(d), 1'b0, w});
  endtask

  task automatic wait_idle(input int d, input int budget);
    int n = 0;
    @(negedge clock);
    while (!(src_q.size() == 0 && cs_n_w[d] && st_of(d) == ST_IDLE) && n < budget) begin
      @(negedge clock);
      n++;
    end
    chk("wait_idle_in_budget", 32'(n < budget), 1);
  endtask

  task automatic clear_times();
    get_t.delete();
    rise_t.delete();
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int n;
    int tog;
    logic last;
    int s0;

    repeat (4) @(negedge clock);
    for (int d = 0; d < 3; d++) begin
      chk("reset_cs_n", cs_n_w[d], 1);
      chk("reset_sclk", sclk_w[d], (d == 1) ? 1 : 0);
      chk("reset_dc", sdc_w[d], 0);
      chk("reset_mosi", mosi_w[d], 0);
      chk("reset_rx_data", rx_of(d), 0);
      chk("reset_rx_valid", rxv_w[d], 0);
      chk("reset_get", get_w[d], 0);
    end
    reset = 1'b0;

    // Single mode-0 word, dc=1, 0xA5.
    active_dut = 0;
    clear_times();
    push_word(0, 1'b1, 9'h0A5);
    wait_idle(0, 200);
    chk("a5_get_count", get_t.size(), 1);
    chk("a5_rise_count", rise_t.size(), 1);
    if (get_t.size() == 1 && rise_t.size() == 1) chk("a5_cs_low_steps", rise_t[0] - get_t[0] + 1, 18);
    chk("a5_dc_held", sdc_w[0], 1);
    chk("a5_mosi_held_last_bit", mosi_w[0], 1);

    // Mode 3, LSB first, W=9, looped back.
    active_dut = 1;
    clear_times();
    push_word(1, 1'b0, 9'h1C3);
    wait_idle(1, 200);
    chk("w9_sclk_idle_high", sclk_w[1], 1);
    chk("w9_rise_count", rise_t.size(), 1);
    if (get_t.size() == 1 && rise_t.size() == 1) chk("w9_cs_low_steps", rise_t[0] - get_t[0] + 1, 20);

    // Three-word burst on mode 0.
    active_dut = 0;
    clear_times();
    push_word(0, 1'b0, 9'h02A);
    push_word(0, 1'b1, 9'h001);
    push_word(0, 1'b1, 9'h0FF);
    wait_idle(0, 400);
    chk("burst_get_count", get_t.size(), 3);
    chk("burst_single_rise", rise_t.size(), 1);
    if (get_t.size() == 3) begin
      chk("burst_spacing_1", get_t[1] - get_t[0], 17);
      chk("burst_spacing_2", get_t[2] - get_t[1], 17);
      if (rise_t.size() == 1) chk("burst_tail_steps", rise_t[0] - get_t[2] + 1, 18);
    end

    // GAP=3: second word arrives while the gap is running.
    active_dut = 2;
    clear_times();
    push_word(2, 1'b0, 9'h03C);
    n = 0;
    while (rise_t.size() == 0 && n < 200) begin
      @(negedge clock);
      n++;
    end
    chk("gap_first_rise_seen", 32'(n < 200), 1);
    push_word(2, 1'b1, 9'h0C3);
    wait_idle(2, 300);
    chk("gap_get_count", get_t.size(), 2);
    if (get_t.size() == 2 && rise_t.size() >= 1) chk("gap_rise_to_get", get_t[1] - rise_t[0], 4);
    chk("gap_no_get_in_gap", gap_bad, 0);

    // Reset at toggle 7 of 0x55, then a clean word.
    active_dut = 0;
    clear_times();
    src_q.push_back({1'b0, 9'h055});
    tog = 0;
    n = 0;
    last = sclk_w[0];
    while (tog < 7 && n < 200) begin
      @(negedge clock);
      n++;
      if (sclk_w[0] != last) begin
        tog++;
        last = sclk_w[0];
      end
    end
    chk("abort_toggle_reached", tog, 7);
    reset = 1'b1;
    @(negedge clock);
    chk("abort_cs_n", cs_n_w[0], 1);
    chk("abort_sclk", sclk_w[0], 0);
    chk("abort_state_idle", st_a, ST_IDLE);
    chk("abort_rx_valid", rxv_w[0], 0);
    reset = 1'b0;
    repeat (40) @(negedge clock);
    clear_times();
    push_word(0, 1'b1, 9'h096);
    wait_idle(0, 200);
    chk("after_abort_rise_count", rise_t.size(), 1);
    if (get_t.size() == 1 && rise_t.size() == 1) chk("after_abort_cs_low_steps", rise_t[0] - get_t[0] + 1, 18);

    // Permanently empty source for 1000 steps.
    idle_watch = 1'b1;
    s0 = step_cnt;
    n = 0;
    while (step_cnt < s0 + 1000 && n < 2200) begin
      @(negedge clock);
      n++;
    end
    idle_watch = 1'b0;
    chk("idle_1000_steps_reached", 32'(step_cnt >= s0 + 1000), 1);
    chk("idle_outputs_quiet", idle_bad, 0);

    chk("no_output_change_without_step", stall_bad, 0);
    chk("no_stray_get", stray_get, 0);
    chk("tx_queue_drained", exp_tx_q.size(), 0);
    chk("rx_queue_drained", exp_rx_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Hard stop if something wedges the sequence.
  initial begin
    #600000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
